// File: rtl/reservation_station_pkg.sv
// Shared constants and types for the ALU reservation station.
// - Width constants for data, addresses, ROB tags and operation enums.
// - ROB_ID_RESET marks an operand whose value is already present.
// - operand_t, rs_entry_t and cdb_t describe one operand, one station entry
//   and one common-data-bus broadcast.
// - snoop() applies both CDB broadcasts to a single waiting operand.
package reservation_station_pkg;

    localparam int DATA_TYPE    = 32;
    localparam int ADDR_TYPE    = 32;
    localparam int ROB_ID_TYPE  = 5;
    localparam int OP_ENUM_TYPE = 6;
    localparam int RS_SIZE      = 16;
    localparam int RS_IDX_WIDTH = 4;

    localparam logic [ROB_ID_TYPE-1:0]  ROB_ID_RESET  = 5'b10000;
    localparam logic [OP_ENUM_TYPE-1:0] OP_ENUM_RESET = '0;

    typedef logic [DATA_TYPE-1:0]    data_t;
    typedef logic [ADDR_TYPE-1:0]    addr_t;
    typedef logic [ROB_ID_TYPE-1:0]  rob_id_t;
    typedef logic [OP_ENUM_TYPE-1:0] op_t;

    typedef struct packed {
        rob_id_t q;     // producer tag, ROB_ID_RESET when v is valid
        data_t   v;
    } operand_t;

    typedef struct packed {
        logic     busy;
        op_t      op;
        operand_t src1;
        operand_t src2;
        data_t    imm;
        addr_t    pos;
        rob_id_t  rob_id;
    } rs_entry_t;

    typedef struct packed {
        logic    valid;
        rob_id_t tag;
        data_t   data;
    } cdb_t;

    // Capture a broadcast result for a waiting operand. The ALU bus wins when
    // both buses carry the same tag; a ready operand is never overwritten.
    function automatic operand_t snoop(operand_t opnd, cdb_t alu, cdb_t lsu);
        operand_t res;
        res = opnd;
        if (opnd.q != ROB_ID_RESET) begin
            if (alu.valid && (alu.tag == opnd.q)) begin
                res.q = ROB_ID_RESET;
                res.v = alu.data;
            end else if (lsu.valid && (lsu.tag == opnd.q)) begin
                res.q = ROB_ID_RESET;
                res.v = lsu.data;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Bus bundle around the reservation station.
// - Dispatcher insert request and is_full back-pressure.
// - ALU and LSU common-data-bus broadcasts, ROB rollback flag.
// - Issue port towards the ALU.
// modport slave  : the reservation station itself.
// modport master : the surrounding pipeline (dispatcher, CDBs, ROB, ALU).
interface reservation_station_if;
    import reservation_station_pkg::*;

    logic    enable_from_dispatcher;
    op_t     op_enum_from_dispatcher;
    data_t   V1_from_dispatcher;
    data_t   V2_from_dispatcher;
    rob_id_t Q1_from_dispatcher;
    rob_id_t Q2_from_dispatcher;
    data_t   imm_from_dispatcher;
    addr_t   inst_pos_from_dispatcher;
    rob_id_t rob_id_from_dispatcher;
    logic    is_full_to_dispatcher;

    logic    enable_from_alu;
    rob_id_t rob_id_from_alu;
    data_t   result_from_alu;
    logic    enable_from_lsu;
    rob_id_t rob_id_from_lsb;
    data_t   result_from_lsu;

    logic    rollback_flag_from_rob;

    logic    enable_to_alu;
    op_t     op_enum_to_alu;
    data_t   V1_to_alu;
    data_t   V2_to_alu;
    data_t   imm_to_alu;
    addr_t   inst_pos_to_alu;
    rob_id_t rob_id_to_alu;

    modport slave (
        input  enable_from_dispatcher, op_enum_from_dispatcher,
               V1_from_dispatcher, V2_from_dispatcher,
               Q1_from_dispatcher, Q2_from_dispatcher,
               imm_from_dispatcher, inst_pos_from_dispatcher,
               rob_id_from_dispatcher,
               enable_from_alu, rob_id_from_alu, result_from_alu,
               enable_from_lsu, rob_id_from_lsb, result_from_lsu,
               rollback_flag_from_rob,
        output is_full_to_dispatcher,
               enable_to_alu, op_enum_to_alu, V1_to_alu, V2_to_alu,
               imm_to_alu, inst_pos_to_alu, rob_id_to_alu
    );

    modport master (
        output enable_from_dispatcher, op_enum_from_dispatcher,
               V1_from_dispatcher, V2_from_dispatcher,
               Q1_from_dispatcher, Q2_from_dispatcher,
               imm_from_dispatcher, inst_pos_from_dispatcher,
               rob_id_from_dispatcher,
               enable_from_alu, rob_id_from_alu, result_from_alu,
               enable_from_lsu, rob_id_from_lsb, result_from_lsu,
               rollback_flag_from_rob,
        input  is_full_to_dispatcher,
               enable_to_alu, op_enum_to_alu, V1_to_alu, V2_to_alu,
               imm_to_alu, inst_pos_to_alu, rob_id_to_alu
    );

endinterface

// File: rtl/reservation_station_encoder.sv
// rs_priority_encoder: finds the lowest set bit of a request vector.
// - req_i   : one request bit per station entry
// - idx_o   : index of the lowest set bit (0 when none set)
// - valid_o : at least one bit set
module rs_priority_encoder #(
    parameter int WIDTH     = 16,
    parameter int IDX_WIDTH = 4
) (
    input  logic [WIDTH-1:0]     req_i,
    output logic [IDX_WIDTH-1:0] idx_o,
    output logic                 valid_o
);

    // Scan from the top down so the last hit is the lowest index.
    always_comb begin
        idx_o = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_WIDTH'(i);
            end
        end
    end

    assign valid_o = |req_i;

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station.
// Holds dispatched ALU-class instructions until both operands are known,
// snoops the ALU and LSU CDBs to wake waiting operands, and issues the
// lowest-index ready entry to the ALU each cycle.
// - clk_in, rst_in (async active-low), rdy_in (global stall when low)
// - rs : reservation_station_if.slave carrying dispatcher, CDB, rollback
//        and ALU issue signals
module reservation_station #(
    parameter int RS_SIZE      = reservation_station_pkg::RS_SIZE,
    parameter int RS_IDX_WIDTH = reservation_station_pkg::RS_IDX_WIDTH
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        rdy_in,
    reservation_station_if.slave        rs
);
    import reservation_station_pkg::*;

    rs_entry_t entries_q [RS_SIZE];
    rs_entry_t entries_d [RS_SIZE];

    logic    enable_to_alu_q, enable_to_alu_d;
    op_t     op_q,   op_d;
    data_t   v1_q,   v1_d;
    data_t   v2_q,   v2_d;
    data_t   imm_q,  imm_d;
    addr_t   pos_q,  pos_d;
    rob_id_t rob_q,  rob_d;

    logic [RS_SIZE-1:0]      busy_vec;
    logic [RS_SIZE-1:0]      free_vec;
    logic [RS_SIZE-1:0]      ready_vec;
    logic [RS_IDX_WIDTH-1:0] free_idx;
    logic [RS_IDX_WIDTH-1:0] ready_idx;
    logic                    free_valid;
    logic                    ready_valid;
    logic [RS_IDX_WIDTH:0]   busy_cnt;

    cdb_t      alu_cdb;
    cdb_t      lsu_cdb;
    rs_entry_t new_entry;

    assign alu_cdb = '{valid: rs.enable_from_alu, tag: rs.rob_id_from_alu,
                       data: rs.result_from_alu};
    assign lsu_cdb = '{valid: rs.enable_from_lsu, tag: rs.rob_id_from_lsb,
                       data: rs.result_from_lsu};

    // Free and ready searches look only at registered state, so a slot freed
    // by this edge's issue cannot be reused until the next cycle and a
    // wakeup on this edge issues one edge later.
    generate
        for (genvar gi = 0; gi < RS_SIZE; gi++) begin : g_vec
            assign busy_vec[gi]  = entries_q[gi].busy;
            assign free_vec[gi]  = ~entries_q[gi].busy;
            assign ready_vec[gi] = entries_q[gi].busy
                                 && (entries_q[gi].src1.q == ROB_ID_RESET)
                                 && (entries_q[gi].src2.q == ROB_ID_RESET);
        end
    endgenerate

    rs_priority_encoder #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_IDX_WIDTH)) u_free_enc (
        .req_i   (free_vec),
        .idx_o   (free_idx),
        .valid_o (free_valid)
    );

    rs_priority_encoder #(.WIDTH(RS_SIZE), .IDX_WIDTH(RS_IDX_WIDTH)) u_ready_enc (
        .req_i   (ready_vec),
        .idx_o   (ready_idx),
        .valid_o (ready_valid)
    );

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            busy_cnt = busy_cnt + (RS_IDX_WIDTH + 1)'(busy_vec[i]);
        end
    end

    // One spare slot absorbs the request already in flight in the
    // dispatcher's output register.
    assign rs.is_full_to_dispatcher = (busy_cnt >= (RS_IDX_WIDTH + 1)'(RS_SIZE - 1));

    // Incoming operands are forwarded from a same-cycle CDB broadcast.
    always_comb begin
        new_entry        = '0;
        new_entry.busy   = 1'b1;
        new_entry.op     = rs.op_enum_from_dispatcher;
        new_entry.src1   = snoop('{q: rs.Q1_from_dispatcher, v: rs.V1_from_dispatcher},
                                 alu_cdb, lsu_cdb);
        new_entry.src2   = snoop('{q: rs.Q2_from_dispatcher, v: rs.V2_from_dispatcher},
                                 alu_cdb, lsu_cdb);
        new_entry.imm    = rs.imm_from_dispatcher;
        new_entry.pos    = rs.inst_pos_from_dispatcher;
        new_entry.rob_id = rs.rob_id_from_dispatcher;
    end

    always_comb begin
        entries_d       = entries_q;
        enable_to_alu_d = 1'b0;
        op_d            = op_q;
        v1_d            = v1_q;
        v2_d            = v2_q;
        imm_d           = imm_q;
        pos_d           = pos_q;
        rob_d           = rob_q;

        if (rdy_in) begin
            if (rs.rollback_flag_from_rob) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    entries_d[i].busy = 1'b0;
                end
            end else begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (entries_q[i].busy) begin
                        entries_d[i].src1 = snoop(entries_q[i].src1, alu_cdb, lsu_cdb);
                        entries_d[i].src2 = snoop(entries_q[i].src2, alu_cdb, lsu_cdb);
                    end
                end

                if (ready_valid) begin
                    enable_to_alu_d             = 1'b1;
                    op_d                        = entries_q[ready_idx].op;
                    v1_d                        = entries_q[ready_idx].src1.v;
                    v2_d                        = entries_q[ready_idx].src2.v;
                    imm_d                       = entries_q[ready_idx].imm;
                    pos_d                       = entries_q[ready_idx].pos;
                    rob_d                       = entries_q[ready_idx].rob_id;
                    entries_d[ready_idx].busy   = 1'b0;
                end

                // free_idx is never the issuing slot: that slot is still busy
                // in the registered state. With no free slot the request drops.
                if (rs.enable_from_dispatcher && free_valid) begin
                    entries_d[free_idx] = new_entry;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < RS_SIZE; i++) begin
                entries_q[i] <= '0;
            end
            enable_to_alu_q <= 1'b0;
            op_q            <= OP_ENUM_RESET;
            v1_q            <= '0;
            v2_q            <= '0;
            imm_q           <= '0;
            pos_q           <= '0;
            rob_q           <= '0;
        end else begin
            entries_q       <= entries_d;
            enable_to_alu_q <= enable_to_alu_d;
            op_q            <= op_d;
            v1_q            <= v1_d;
            v2_q            <= v2_d;
            imm_q           <= imm_d;
            pos_q           <= pos_d;
            rob_q           <= rob_d;
        end
    end

    assign rs.enable_to_alu   = enable_to_alu_q;
    assign rs.op_enum_to_alu  = op_q;
    assign rs.V1_to_alu       = v1_q;
    assign rs.V2_to_alu       = v2_q;
    assign rs.imm_to_alu      = imm_q;
    assign rs.inst_pos_to_alu = pos_q;
    assign rs.rob_id_to_alu   = rob_q;

endmodule

// File: tb/tb_reservation_station.sv
// Directed testbench for reservation_station: insert/issue latency, CDB
// wakeup and forwarding, full threshold, rollback, stall and async reset.
module tb_reservation_station;
    import reservation_station_pkg::*;

    logic clk_in;
    logic rst_in;
    logic rdy_in;

    int tests_run;
    int tests_failed;

    reservation_station_if rs_if ();

    reservation_station dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rs     (rs_if)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle_bus();
        rs_if.enable_from_dispatcher = 1'b0;
        rs_if.enable_from_alu        = 1'b0;
        rs_if.enable_from_lsu        = 1'b0;
        rs_if.rollback_flag_from_rob = 1'b0;
    endtask

    task automatic drive_insert(input logic [5:0] op, input logic [31:0] v1, input logic [31:0] v2,
                                input logic [4:0] q1, input logic [4:0] q2,
                                input logic [31:0] imm, input logic [4:0] rob);
        rs_if.enable_from_dispatcher   = 1'b1;
        rs_if.op_enum_from_dispatcher  = op;
        rs_if.V1_from_dispatcher       = v1;
        rs_if.V2_from_dispatcher       = v2;
        rs_if.Q1_from_dispatcher       = q1;
        rs_if.Q2_from_dispatcher       = q2;
        rs_if.imm_from_dispatcher      = imm;
        rs_if.inst_pos_from_dispatcher = 32'h1000 + {27'd0, rob};
        rs_if.rob_id_from_dispatcher   = rob;
    endtask

    task automatic drive_alu(input logic [4:0] tag, input logic [31:0] data);
        rs_if.enable_from_alu = 1'b1;
        rs_if.rob_id_from_alu = tag;
        rs_if.result_from_alu = data;
    endtask

    task automatic drive_lsu(input logic [4:0] tag, input logic [31:0] data);
        rs_if.enable_from_lsu = 1'b1;
        rs_if.rob_id_from_lsb = tag;
        rs_if.result_from_lsu = data;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_in = 1'b0;
        rdy_in = 1'b1;
        idle_bus();
        rs_if.op_enum_from_dispatcher  = '0;
        rs_if.V1_from_dispatcher       = '0;
        rs_if.V2_from_dispatcher       = '0;
        rs_if.Q1_from_dispatcher       = ROB_ID_RESET;
        rs_if.Q2_from_dispatcher       = ROB_ID_RESET;
        rs_if.imm_from_dispatcher      = '0;
        rs_if.inst_pos_from_dispatcher = '0;
        rs_if.rob_id_from_dispatcher   = '0;
        rs_if.rob_id_from_alu          = '0;
        rs_if.result_from_alu          = '0;
        rs_if.rob_id_from_lsb          = '0;
        rs_if.result_from_lsu          = '0;

        // Reset state
        #1;
        check("rst_en",      64'(rs_if.enable_to_alu), 64'd0);
        check("rst_full",    64'(rs_if.is_full_to_dispatcher), 64'd0);
        check("rst_v1",      64'(rs_if.V1_to_alu), 64'd0);
        check("rst_rob",     64'(rs_if.rob_id_to_alu), 64'd0);
        tick();
        tick();
        rst_in = 1'b1;

        // ADDI with both operands ready: issues one edge after insert
        drive_insert(6'd5, 32'd5, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd3, 5'd2);
        tick();
        idle_bus();
        check("addi_en_ins", 64'(rs_if.enable_to_alu), 64'd0);
        tick();
        check("addi_en",     64'(rs_if.enable_to_alu), 64'd1);
        check("addi_op",     64'(rs_if.op_enum_to_alu), 64'd5);
        check("addi_v1",     64'(rs_if.V1_to_alu), 64'd5);
        check("addi_imm",    64'(rs_if.imm_to_alu), 64'd3);
        check("addi_rob",    64'(rs_if.rob_id_to_alu), 64'd2);
        check("addi_pos",    64'(rs_if.inst_pos_to_alu), 64'h1002);
        tick();
        check("addi_en_off", 64'(rs_if.enable_to_alu), 64'd0);
        check("addi_hold",   64'(rs_if.rob_id_to_alu), 64'd2);

        // ADD waiting on tag 4, ALU broadcast two cycles after insert
        drive_insert(6'd1, 32'd0, 32'd9, 5'd4, ROB_ID_RESET, 32'd0, 5'd3);
        tick();
        idle_bus();
        tick();
        check("add_wait",    64'(rs_if.enable_to_alu), 64'd0);
        drive_alu(5'd4, 32'h77);
        tick();
        idle_bus();
        check("add_wake_edge", 64'(rs_if.enable_to_alu), 64'd0);
        tick();
        check("add_en",      64'(rs_if.enable_to_alu), 64'd1);
        check("add_v1",      64'(rs_if.V1_to_alu), 64'h77);
        check("add_v2",      64'(rs_if.V2_to_alu), 64'd9);
        check("add_rob",     64'(rs_if.rob_id_to_alu), 64'd3);
        tick();

        // Q2 forwarded from a same-edge LSU broadcast
        drive_insert(6'd2, 32'd1, 32'd0, ROB_ID_RESET, 5'd7, 32'd0, 5'd4);
        drive_lsu(5'd7, 32'hAB);
        tick();
        idle_bus();
        check("fwd_ins",     64'(rs_if.enable_to_alu), 64'd0);
        tick();
        check("fwd_en",      64'(rs_if.enable_to_alu), 64'd1);
        check("fwd_v2",      64'(rs_if.V2_to_alu), 64'hAB);
        check("fwd_rob",     64'(rs_if.rob_id_to_alu), 64'd4);
        tick();

        // Both operands wake on one edge from different buses
        drive_insert(6'd3, 32'd0, 32'd0, 5'd8, 5'd9, 32'd0, 5'd5);
        tick();
        idle_bus();
        drive_alu(5'd8, 32'h11);
        drive_lsu(5'd9, 32'h22);
        tick();
        idle_bus();
        tick();
        check("dual_en",     64'(rs_if.enable_to_alu), 64'd1);
        check("dual_v1",     64'(rs_if.V1_to_alu), 64'h11);
        check("dual_v2",     64'(rs_if.V2_to_alu), 64'h22);
        tick();

        // Same tag on both buses: ALU value wins
        drive_insert(6'd4, 32'd0, 32'd0, 5'd12, ROB_ID_RESET, 32'd0, 5'd6);
        tick();
        idle_bus();
        drive_alu(5'd12, 32'hA1);
        drive_lsu(5'd12, 32'hB2);
        tick();
        idle_bus();
        tick();
        check("prio_en",     64'(rs_if.enable_to_alu), 64'd1);
        check("prio_v1",     64'(rs_if.V1_to_alu), 64'hA1);
        tick();

        // rdy_in low: insert ignored, ready entry holds without issuing
        rdy_in = 1'b0;
        drive_insert(6'd6, 32'd0, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd0, 5'd7);
        tick();
        idle_bus();
        rdy_in = 1'b1;
        tick();
        check("stall_drop",  64'(rs_if.enable_to_alu), 64'd0);
        drive_insert(6'd6, 32'd0, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd0, 5'd8);
        tick();
        idle_bus();
        rdy_in = 1'b0;
        tick();
        check("stall_hold",  64'(rs_if.enable_to_alu), 64'd0);
        rdy_in = 1'b1;
        tick();
        check("stall_rel_en",  64'(rs_if.enable_to_alu), 64'd1);
        check("stall_rel_rob", 64'(rs_if.rob_id_to_alu), 64'd8);
        tick();

        // Fill: entry i waits on tag i
        for (int i = 0; i < 15; i++) begin
            drive_insert(6'd1, 32'd0, 32'd0, 5'(i), ROB_ID_RESET, 32'd0, 5'(i));
            tick();
            if (i == 13) check("fill14_full", 64'(rs_if.is_full_to_dispatcher), 64'd0);
        end
        check("fill15_full", 64'(rs_if.is_full_to_dispatcher), 64'd1);
        drive_insert(6'd1, 32'd0, 32'd0, 5'd15, ROB_ID_RESET, 32'd0, 5'd15);
        tick();
        check("fill16_full", 64'(rs_if.is_full_to_dispatcher), 64'd1);
        // 17th request is ready; it would issue next edge if it were accepted
        drive_insert(6'd1, 32'd0, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd0, 5'd17);
        tick();
        idle_bus();
        tick();
        check("drop17_en",   64'(rs_if.enable_to_alu), 64'd0);
        drive_alu(5'd5, 32'h55);
        tick();
        idle_bus();
        tick();
        check("wake5_en",    64'(rs_if.enable_to_alu), 64'd1);
        check("wake5_rob",   64'(rs_if.rob_id_to_alu), 64'd5);
        check("wake5_v1",    64'(rs_if.V1_to_alu), 64'h55);
        check("free1_full",  64'(rs_if.is_full_to_dispatcher), 64'd1);
        drive_alu(5'd6, 32'h66);
        tick();
        idle_bus();
        tick();
        check("wake6_rob",   64'(rs_if.rob_id_to_alu), 64'd6);
        check("free2_full",  64'(rs_if.is_full_to_dispatcher), 64'd0);

        // Flush the remaining 14 entries
        rs_if.rollback_flag_from_rob = 1'b1;
        tick();
        idle_bus();
        check("flush_full",  64'(rs_if.is_full_to_dispatcher), 64'd0);
        drive_alu(5'd7, 32'h70);
        tick();
        idle_bus();
        tick();
        check("flush_no_issue", 64'(rs_if.enable_to_alu), 64'd0);

        // Three waiting entries, then rollback concurrent with an insert
        for (int i = 0; i < 3; i++) begin
            drive_insert(6'd1, 32'd0, 32'd0, 5'd3, ROB_ID_RESET, 32'd0, 5'(10 + i));
            tick();
        end
        drive_insert(6'd1, 32'd0, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd0, 5'd13);
        rs_if.rollback_flag_from_rob = 1'b1;
        tick();
        idle_bus();
        check("rb_en",       64'(rs_if.enable_to_alu), 64'd0);
        check("rb_full",     64'(rs_if.is_full_to_dispatcher), 64'd0);
        drive_alu(5'd3, 32'h33);
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_bus();
            check($sformatf("rb_quiet%0d", i), 64'(rs_if.enable_to_alu), 64'd0);
        end

        // Asynchronous reset while an issue is on the bus
        drive_insert(6'd9, 32'h1234, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd0, 5'd21);
        tick();
        drive_insert(6'd9, 32'h5678, 32'd0, ROB_ID_RESET, ROB_ID_RESET, 32'd0, 5'd22);
        tick();
        idle_bus();
        check("arst_pre_en",  64'(rs_if.enable_to_alu), 64'd1);
        check("arst_pre_v1",  64'(rs_if.V1_to_alu), 64'h1234);
        #2;
        rst_in = 1'b0;
        #1;
        check("arst_en",      64'(rs_if.enable_to_alu), 64'd0);
        check("arst_v1",      64'(rs_if.V1_to_alu), 64'd0);
        check("arst_rob",     64'(rs_if.rob_id_to_alu), 64'd0);
        #3;
        rst_in = 1'b1;
        tick();
        check("arst_post0",   64'(rs_if.enable_to_alu), 64'd0);
        tick();
        check("arst_post1",   64'(rs_if.enable_to_alu), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/reservation_station.md
Name: reservation_station

Overview:
Holds ALU-class (non-load/store) instructions issued by the dispatcher until both source operands are available. Snoops the ALU and LSU CDB broadcasts to wake waiting operands. Issues one ready instruction per cycle to the ALU. Sits directly downstream of the dispatcher and upstream of the ALU.

Parameters:
RS_SIZE, 16, number of entries; must be a power of two, at least 4.
RS_IDX_WIDTH, 4, log2(RS_SIZE).

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-low reset
rdy_in  input  1  global ready; low freezes all state
enable_from_dispatcher  input  1  insert request, registered by the dispatcher
op_enum_from_dispatcher  input  6  operation enum
V1_from_dispatcher  input  32  operand 1 value
V2_from_dispatcher  input  32  operand 2 value
Q1_from_dispatcher  input  5  operand 1 producer tag; ROB_ID_RESET means ready
Q2_from_dispatcher  input  5  operand 2 producer tag; ROB_ID_RESET means ready
imm_from_dispatcher  input  32  immediate
inst_pos_from_dispatcher  input  32  instruction PC
rob_id_from_dispatcher  input  5  destination ROB tag
is_full_to_dispatcher  output  1  fewer than 2 free entries
enable_from_alu  input  1  ALU CDB valid
rob_id_from_alu  input  5  ALU CDB tag
result_from_alu  input  32  ALU CDB data
enable_from_lsu  input  1  LSU CDB valid
rob_id_from_lsb  input  5  LSU CDB tag
result_from_lsu  input  32  LSU CDB data
rollback_flag_from_rob  input  1  misprediction flush
enable_to_alu  output  1  issue valid, one cycle
op_enum_to_alu  output  6  issued operation
V1_to_alu  output  32  issued operand 1
V2_to_alu  output  32  issued operand 2
imm_to_alu  output  32  issued immediate
inst_pos_to_alu  output  32  issued PC
rob_id_to_alu  output  5  issued tag

Behaviour:
- Reset (rst_in low, asynchronous): all busy bits = 0, all *_to_alu outputs = 0, is_full_to_dispatcher = 0.
- Entry fields: busy, op, V1, V2, Q1, Q2, imm, pos, rob_id.
- is_full_to_dispatcher: combinational from the registered busy count; asserted when free entries ≤ 1. The margin of 1 covers the dispatcher's one-cycle registered latency.
- Insert: on a clock edge with rdy_in high, no rollback and enable_from_dispatcher high:
  - The lowest-index free entry is written and its busy bit set.
  - If an incoming Qk matches a live CDB tag in the same cycle, the entry stores the CDB data and Qk = ROB_ID_RESET.
  - Insert while no entry is free is a protocol error; the request is dropped.
- Wakeup: every edge, each busy entry with Qk == rob_id_from_alu (when enable_from_alu) or Qk == rob_id_from_lsb (when enable_from_lsu) captures the matching result and sets Qk = ROB_ID_RESET.
  - Q1 and Q2 are handled independently; both may wake in the same edge.
  - ALU takes priority if both CDBs carry the same tag.
  - A ROB_ID_RESET tag never matches.
- Ready = busy && Q1 == ROB_ID_RESET && Q2 == ROB_ID_RESET, evaluated on the registered entry state only. A cycle-t wakeup makes the entry issuable at edge t+1 at the earliest.
- Issue:
  - Each edge, the lowest-index ready entry is copied into the *_to_alu registers, enable_to_alu is set to 1, and the entry's busy bit is cleared.
  - If no entry is ready, enable_to_alu = 0 and the other outputs hold.
  - Minimum latency: insert at edge t, issue at edge t+1, ALU sees enable_to_alu during cycle t+1.
- Simultaneous events:
  - Issue and insert on the same edge are allowed.
  - A newly inserted entry never uses the slot being freed on that edge; freed slots become visible next cycle.
- Rollback (rollback_flag_from_rob high at an edge, rdy_in high): all busy bits cleared, enable_to_alu = 0, insert ignored, wakeup irrelevant. Takes priority over everything except reset.
- rdy_in low: no insert, wakeup, issue or flush; enable_to_alu = 0; entries hold.

Decomposition:
- Shared constants header: DATA_TYPE (32), ADDR_TYPE (32), ROB_ID_TYPE (5), ROB_ID_RESET (5'b10000), OP_ENUM_TYPE (6), OP_ENUM_RESET, RS_SIZE.
- One sub-module, rs_priority_encoder: RS_SIZE-bit request vector in, lowest-set index plus valid flag out. Instantiated twice, once for the free search and once for the ready search.

Test Plan:
- Insert ADDI (Q1 = Q2 = 16, V1 = 5, imm = 3, rob_id = 2) at edge 0 -> enable_to_alu = 1 in the following cycle with V1 = 5, imm = 3, rob_id = 2; then 0.
- Insert ADD with Q1 = 4; ALU CDB tag 4 with data 0x77 two cycles later -> issues exactly one edge after the broadcast with V1 = 0x77.
- Insert with Q2 = 7 while LSU CDB broadcasts tag 7, data 0xAB on the same edge -> stored V2 = 0xAB; issues on the next edge.
- Fill 15 waiting entries -> is_full = 1; insert the 16th; the dispatcher's 17th request is dropped; one wakeup issues an entry and is_full stays 1 until the free count reaches 2.
- 3 busy entries plus rollback_flag_from_rob concurrent with an insert -> next cycle all empty, is_full = 0, no issue afterwards.
- Assert rst_in low mid-stream while enable_to_alu = 1 -> outputs 0 immediately (asynchronous), no issue after release.
